// File: rtl/fetch_unit.sv
// fetch_unit -- single-outstanding instruction fetch stage.
//
// Issues one instruction-memory read at a time from the PC register,
// captures the response into a registered decode slot, and waits for
// decode to take it before issuing the next read. A redirect (branch,
// jump or trap) reloads the PC and squashes whatever is in flight; a
// response still owed by memory for a squashed request is swallowed in
// the DROP state so it can never reach decode.
//
// Ports
//   clk, rst         : clock, synchronous active-high reset
//   redirect_valid   : load PC from redirect_pc (bits [1:0] forced to 0)
//   redirect_pc      : redirect target
//   imem_req_valid   : read request, address = imem_req_addr (the PC)
//   imem_req_ready   : memory accepts the request this cycle
//   imem_resp_valid  : imem_resp_data holds the read data
//   imem_resp_data   : fetched instruction word
//   if_valid         : decode slot holds a valid instruction
//   if_pc, if_instr  : PC and word of the presented instruction
//   if_ready         : decode takes the instruction this cycle
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  input  logic        if_ready
);

  localparam logic [31:0] PC_INIT = RESET_PC & 32'hFFFF_FFFC;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_e;

  state_e      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic        r_if_valid, w_if_valid_nxt;
  logic [31:0] r_if_pc, w_if_pc_nxt;
  logic [31:0] r_if_instr, w_if_instr_nxt;
  logic [31:0] w_redirect_pc;

  assign w_redirect_pc = redirect_pc & 32'hFFFF_FFFC;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_REQ;
      r_pc       <= PC_INIT;
      r_if_valid <= 1'b0;
      r_if_pc    <= '0;
      r_if_instr <= NOP;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_if_valid <= w_if_valid_nxt;
      r_if_pc    <= w_if_pc_nxt;
      r_if_instr <= w_if_instr_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_if_valid_nxt = r_if_valid;
    w_if_pc_nxt    = r_if_pc;
    w_if_instr_nxt = r_if_instr;
    if (redirect_valid) begin
      // Redirect wins over every other event. Where it lands depends on
      // whether memory still owes us a response for an old request.
      w_pc_nxt       = w_redirect_pc;
      w_if_valid_nxt = 1'b0;
      unique case (r_state)
        S_REQ:   w_state_nxt = imem_req_ready  ? S_DROP : S_REQ;
        S_WAIT:  w_state_nxt = imem_resp_valid ? S_REQ  : S_DROP;
        S_HOLD:  w_state_nxt = S_REQ;
        S_DROP:  w_state_nxt = imem_resp_valid ? S_REQ  : S_DROP;
        default: w_state_nxt = S_REQ;
      endcase
    end else begin
      unique case (r_state)
        S_REQ: if (imem_req_ready) w_state_nxt = S_WAIT;
        S_WAIT: if (imem_resp_valid) begin
          w_if_valid_nxt = 1'b1;
          w_if_pc_nxt    = r_pc;
          w_if_instr_nxt = imem_resp_data;
          w_pc_nxt       = r_pc + 32'd4;  // wraps naturally at 2^32
          w_state_nxt    = S_HOLD;
        end
        S_HOLD: if (if_ready) begin
          w_if_valid_nxt = 1'b0;
          w_state_nxt    = S_REQ;
        end
        // Stale response for a squashed request: swallow it untouched.
        S_DROP: if (imem_resp_valid) w_state_nxt = S_REQ;
        default: w_state_nxt = S_REQ;
      endcase
    end
  end

  // Gated with rst so no request escapes during the reset cycle itself.
  assign imem_req_valid = (r_state == S_REQ) && !rst;
  assign imem_req_addr  = r_pc;
  assign if_valid       = r_if_valid;
  assign if_pc          = r_if_pc;
  assign if_instr       = r_if_instr;

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenarios followed by a randomized
// run. A memory responder and a scoreboard monitor run as independent
// processes; the driver seeds the expected program-order stream on every
// reset/redirect and the monitor checks each instruction decode accepts.
module tb_fetch_unit;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready, imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        if_valid;
  logic [31:0] if_pc, if_instr;
  logic        if_ready = 1'b0;

  // Memory side: driver-owned manual values or responder-owned auto values.
  bit          manual = 1'b1;
  logic        m_ready = 1'b0, m_rv = 1'b0;
  logic [31:0] m_rd = '0;
  logic        a_ready = 1'b0, a_rv = 1'b0;
  logic [31:0] a_rd = '0;
  int          lat_max = 1, rdy_pct = 100, spur_pct = 0;

  assign imem_req_ready  = manual ? m_ready : a_ready;
  assign imem_resp_valid = manual ? m_rv    : a_rv;
  assign imem_resp_data  = manual ? m_rd    : a_rd;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr), .if_ready(if_ready)
  );

  int errs = 0, chks = 0, cyc = 0, hs_cnt = 0;
  int hs_cyc[$];
  logic [31:0] last_hs_pc = '0;

  typedef struct {logic [31:0] pc; logic [31:0] instr;} exp_t;
  exp_t exp_q[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Program order restarts at the (word-aligned) target.
  function automatic void expect_stream(input logic [31:0] target);
    logic [31:0] p;
    p = target & 32'hFFFF_FFFC;
    exp_q.delete();
    exp_q.push_back('{pc: p, instr: mem_word(p)});
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    chks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Memory responder: random ready, 1..lat_max cycle latency, optional
  // spurious resp_valid when nothing is outstanding.
  initial begin
    bit acc, rs, r, pend;
    int cnt;
    logic [31:0] a, paddr;
    pend = 0; cnt = 0; paddr = '0;
    forever begin
      @(negedge clk);
      acc = imem_req_valid && imem_req_ready;
      rs  = imem_resp_valid;
      r   = rst;
      a   = imem_req_addr;
      @(posedge clk); #1;
      if (manual) begin
        pend = 0; a_ready = 0; a_rv = 0;
        continue;
      end
      if (r || rs) pend = 0;
      if (acc) begin
        chk1("one_outstanding", pend, 1'b0);
        pend = 1; cnt = $urandom_range(lat_max, 1); paddr = a;
      end
      if (pend && cnt <= 1) begin
        a_rv = 1; a_rd = mem_word(paddr);
      end else begin
        if (pend) cnt--;
        a_rv = !pend && ($urandom_range(99, 0) < spur_pct);
        a_rd = 32'hBAD0_0000 ^ $urandom_range(16'hFFFF, 0);
      end
      a_ready = ($urandom_range(99, 0) < rdy_pct);
    end
  end

  // Monitor / scoreboard.
  initial begin
    logic p_rst = 1'b1, p_redir = 1'b0, p_valid = 1'b0, p_ready = 1'b0, p_hs = 1'b0;
    logic [31:0] p_pc = '0, p_instr = '0;
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        chk1("req_valid_during_rst", imem_req_valid, 1'b0);
      end else begin
        if (p_rst) begin
          chk1("rst_if_valid", if_valid, 1'b0);
          chk("rst_if_pc", if_pc, 32'h0);
          chk("rst_if_instr", if_instr, 32'h0000_0013);
          chk1("rst_req_valid", imem_req_valid, 1'b1);
          chk("rst_req_addr", imem_req_addr, RPC);
        end else if (p_redir) begin
          chk1("redirect_clears_valid", if_valid, 1'b0);
        end else if (p_hs) begin
          chk1("accept_clears_valid", if_valid, 1'b0);
        end else if (p_valid && !p_ready) begin
          chk1("hold_valid", if_valid, 1'b1);
          chk("hold_pc", if_pc, p_pc);
          chk("hold_instr", if_instr, p_instr);
        end
        if (if_valid) chk1("no_req_while_presenting", imem_req_valid, 1'b0);
        if (imem_req_valid) chk("req_addr_aligned", {30'b0, imem_req_addr[1:0]}, 32'h0);
        if (if_valid && if_ready && !redirect_valid) begin
          hs_cnt++;
          hs_cyc.push_back(cyc);
          last_hs_pc = if_pc;
          if (exp_q.size() == 0) begin
            chks++; errs++;
            $display("FAIL sb_empty: unexpected instr pc=%h instr=%h", if_pc, if_instr);
          end else begin
            e = exp_q.pop_front();
            chk("if_pc", if_pc, e.pc);
            chk("if_instr", if_instr, e.instr);
            exp_q.push_back('{pc: e.pc + 32'd4, instr: mem_word(e.pc + 32'd4)});
          end
        end
      end
      p_rst   = rst;
      p_redir = redirect_valid;
      p_valid = if_valid;
      p_ready = if_ready;
      p_pc    = if_pc;
      p_instr = if_instr;
      p_hs    = if_valid && if_ready && !redirect_valid && !rst;
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic do_reset(input bit auto_after);
    manual = 1; m_ready = 0; m_rv = 0; redirect_valid = 0; rst = 1;
    expect_stream(RPC);
    tick();
    if (auto_after) manual = 0;
    tick();
    rst = 0;
  endtask

  task automatic wait_hs(input int n, input int maxc, input string nm);
    int start, k;
    start = hs_cnt; k = 0;
    while (hs_cnt < start + n && k < maxc) begin tick(); k++; end
    chks++;
    if (hs_cnt < start + n) begin
      errs++;
      $display("FAIL %s: %0d of %0d instructions within %0d cycles", nm, hs_cnt - start, n, maxc);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    errs++;
    $display("Result: errors=%0d of %0d checks", errs, chks);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    bit seen;
    logic [31:0] spc, sins, ra;

    // Straight-line fetch, memory always ready with 1-cycle latency.
    lat_max = 1; rdy_pct = 100; spur_pct = 0; if_ready = 1;
    do_reset(1);
    c0 = cyc + 1;
    hs_cyc.delete();
    wait_hs(3, 30, "seq_progress");
    for (int i = 0; i < 3; i++)
      chk("seq_cadence", 32'((hs_cyc.size() > i) ? hs_cyc[i] : -1), 32'(c0 + 2 + 3 * i));

    // Decode stalls for 5 cycles in HOLD.
    if_ready = 0;
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin @(negedge clk); seen = if_valid; end
    chk1("stall_reach_hold", seen, 1'b1);
    spc = if_pc; sins = if_instr;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      chk1("stall_valid", if_valid, 1'b1);
      chk("stall_pc", if_pc, spc);
      chk("stall_instr", if_instr, sins);
      chk1("stall_no_req", imem_req_valid, 1'b0);
    end
    tick(); if_ready = 1;
    wait_hs(1, 10, "stall_release");

    // Redirect in WAIT; stale 0xDEADBEEF arrives two cycles later.
    do_reset(0);
    m_ready = 1; tick();
    m_ready = 0; redirect_valid = 1; redirect_pc = 32'h0000_0100;
    expect_stream(32'h0000_0100); tick();
    redirect_valid = 0; tick();
    m_rv = 1; m_rd = 32'hDEAD_BEEF; tick();
    m_rv = 0;
    @(negedge clk);
    chk1("drop_if_valid", if_valid, 1'b0);
    chk1("drop_req_valid", imem_req_valid, 1'b1);
    chk("drop_req_addr", imem_req_addr, 32'h0000_0100);
    tick(); manual = 0;
    wait_hs(1, 20, "redirect_refetch");

    // Reset while WAIT, then the late response shows up.
    do_reset(0);
    m_ready = 1; tick();
    m_ready = 0; rst = 1; expect_stream(RPC); tick();
    rst = 0; m_rv = 1; m_rd = 32'hDEAD_BEEF; tick();
    m_rv = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk1("late_if_valid", if_valid, 1'b0);
      chk1("late_req_valid", imem_req_valid, 1'b1);
      chk("late_req_addr", imem_req_addr, RPC);
    end
    tick(); manual = 0;
    wait_hs(1, 20, "reset_refetch");

    // Redirect to the top of the address space (low bits must be ignored).
    tick();
    redirect_valid = 1; redirect_pc = 32'hFFFF_FFFF; expect_stream(32'hFFFF_FFFF);
    tick();
    redirect_valid = 0;
    wait_hs(2, 40, "wrap_progress");
    chk("wrap_second_pc", last_hs_pc, 32'h0000_0000);

    // Randomized traffic: stalls, latency, spurious responses, redirects, resets.
    lat_max = 3; rdy_pct = 70; spur_pct = 15;
    c0 = hs_cnt;
    for (int i = 0; i < 4000; i++) begin
      tick();
      if_ready = ($urandom_range(3, 0) != 0);
      if ($urandom_range(399, 0) == 0) begin
        rst = 1; redirect_valid = 0; expect_stream(RPC);
      end else begin
        rst = 0;
        redirect_valid = ($urandom_range(15, 0) == 0);
        if (redirect_valid) begin
          case ($urandom_range(3, 0))
            0:       ra = 32'hFFFF_FFFC - 32'($urandom_range(2, 0) * 4);
            1:       ra = $urandom;
            default: ra = 32'($urandom_range(255, 0)) << 2;
          endcase
          redirect_pc = ra;
          expect_stream(ra);
        end
      end
    end
    tick();
    rst = 0; redirect_valid = 0; if_ready = 1;
    wait_hs(1, 40, "random_final");
    chks++;
    if (hs_cnt - c0 < 150) begin
      errs++;
      $display("FAIL random_progress: got %0d instructions expected at least 150", hs_cnt - c0);
    end
    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the PC loaded on reset; bits [1:0] SHALL be treated as zero.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-004 redirect_valid  input  1  SHALL indicate a taken branch, jump or trap requiring a PC change.
REQ-005 redirect_pc  input  32  SHALL carry the redirect target; bits [1:0] SHALL be ignored and forced to 0.
REQ-006 imem_req_valid  output  1  SHALL indicate an instruction-memory read request.
REQ-007 imem_req_addr  output  32  SHALL carry the request address, equal to the PC register.
REQ-008 imem_req_ready  input  1  SHALL indicate the memory accepts the request this cycle.
REQ-009 imem_resp_valid  input  1  SHALL indicate that imem_resp_data holds the response.
REQ-010 imem_resp_data  input  32  SHALL carry the fetched instruction word.
REQ-011 if_valid  output  1  SHALL indicate a valid instruction to decode.
REQ-012 if_pc  output  32  SHALL carry the PC of the presented instruction.
REQ-013 if_instr  output  32  SHALL carry the presented instruction word.
REQ-014 if_ready  input  1  SHALL indicate decode accepts the instruction this cycle.

Function
REQ-015 The block SHALL implement states REQ, WAIT, HOLD and DROP, with at most one outstanding memory request.
REQ-016 REQ: imem_req_valid=1 and imem_req_addr=PC; a cycle with imem_req_ready=1 SHALL move the block to WAIT.
REQ-017 WAIT/HOLD/DROP: imem_req_valid SHALL be 0.
REQ-018 WAIT with imem_resp_valid=1 SHALL register if_instr=imem_resp_data, if_pc=PC and if_valid=1 for the next cycle, set PC=PC+4, and go to HOLD.
REQ-019 PC+4 SHALL be computed modulo 2^32; 32'hFFFF_FFFC SHALL wrap to 32'h0000_0000.
REQ-020 HOLD: if_valid, if_pc and if_instr SHALL remain stable while if_ready=0.
REQ-021 HOLD with if_ready=1: if_valid SHALL be 0 the next cycle and the state SHALL become REQ; minimum fetch latency is 3 cycles per instruction.
REQ-022 imem_resp_valid SHALL be ignored in REQ and HOLD, where no request is outstanding.
REQ-023 redirect_valid=1 SHALL load PC with redirect_pc next cycle and clear if_valid next cycle; it SHALL take priority over all events except rst.
REQ-024 Redirect in REQ: if imem_req_ready=1 in the same cycle, go to DROP; otherwise stay in REQ and issue the new address next cycle. The address change while imem_req_valid=1 is permitted only in this case.
REQ-025 Redirect in WAIT: if imem_resp_valid=1 in the same cycle, discard the response and go to REQ; otherwise go to DROP.
REQ-026 Redirect in HOLD: discard the held instruction and go to REQ, regardless of if_ready.
REQ-027 Redirect in DROP: remain in DROP, or go to REQ if imem_resp_valid=1 in the same cycle.
REQ-028 DROP: the first imem_resp_valid=1 SHALL be discarded without updating if_* or PC, and the state SHALL become REQ.
REQ-029 Redirects on consecutive cycles: the last one SHALL win.

Reset
REQ-030 rst=1 SHALL set PC=RESET_PC, state=REQ, if_valid=0, if_pc=0 and if_instr=32'h0000_0013 (NOP).
REQ-031 imem_req_valid SHALL be 0 in any cycle with rst=1.
REQ-032 rst asserted mid-transaction (WAIT or DROP) SHALL abandon the request; the memory subsystem is reset by the same rst.

Verification
REQ-033 Reset with RESET_PC=0, then release rst -> the first cycle after release shows imem_req_valid=1 and imem_req_addr=0x0000_0000.
REQ-034 Memory always ready, 1-cycle response, if_ready=1 -> if_pc sequence 0x0, 0x4, 0x8 with matching if_instr; one instruction every 3 cycles.
REQ-035 if_ready=0 for 5 cycles in HOLD -> if_valid=1 with if_pc/if_instr unchanged throughout, and imem_req_valid=0.
REQ-036 Redirect to 0x0000_0100 while in WAIT, stale response 0xDEADBEEF arrives 2 cycles later -> response dropped, never presented; next request address is 0x100.
REQ-037 Redirect to 0xFFFF_FFFC -> fetch 0xFFFF_FFFC, then request address 0x0000_0000.
REQ-038 rst pulse while in WAIT, followed by the late response -> if_valid stays 0 and the request restarts at RESET_PC.
